// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register: takes op/amount/data over valid/ready and runs shifts one bit per clock.
// Latency: LOAD/CLEAR/NOP and zero-amount shifts finish on the accept edge; k-bit shifts take k edges. done follows; cmd_ready returns after done.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid at any other time is ignored, not queued.
module param_universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] outp,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             ser_out_q, ser_out_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  logic [AMT_W-1:0] amt_clamped;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  assign amt_clamped = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
  // On the accept edge the op has not been latched yet, so use the live command.
  assign step_op     = (state_q == ST_IDLE) ? cmd_op : op_q;

  always_comb begin
    step_val = outp_q;
    step_bit = ser_out_q;
    case (step_op)
      OP_SHR: begin
        step_val = {ser_in, outp_q[WIDTH-1:1]};
        step_bit = outp_q[0];
      end
      OP_SHL: begin
        step_val = {outp_q[WIDTH-2:0], ser_in};
        step_bit = outp_q[WIDTH-1];
      end
      OP_ROR: begin
        step_val = {outp_q[0], outp_q[WIDTH-1:1]};
        step_bit = outp_q[0];
      end
      OP_ROL: begin
        step_val = {outp_q[WIDTH-2:0], outp_q[WIDTH-1]};
        step_bit = outp_q[WIDTH-1];
      end
      OP_ASR: begin
        step_val = {outp_q[WIDTH-1], outp_q[WIDTH-1:1]};
        step_bit = outp_q[0];
      end
      default: begin
        step_val = outp_q;
        step_bit = ser_out_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    outp_d    = outp_q;
    ser_out_d = ser_out_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          case (cmd_op)
            OP_NOP: state_d = ST_DONE;
            OP_LOAD: begin
              outp_d  = cmd_data;
              state_d = ST_DONE;
            end
            OP_CLEAR: begin
              outp_d    = '0;
              ser_out_d = 1'b0;
              state_d   = ST_DONE;
            end
            default: begin
              if (amt_clamped == '0) begin
                state_d = ST_DONE;
              end else begin
                outp_d    = step_val;
                ser_out_d = step_bit;
                cnt_d     = amt_clamped - AMT_ONE;
                state_d   = (amt_clamped == AMT_ONE) ? ST_DONE : ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        outp_d    = step_val;
        ser_out_d = step_bit;
        cnt_d     = cnt_q - AMT_ONE;
        if (cnt_q == AMT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      outp_q    <= '0;
      ser_out_q <= 1'b0;
      op_q      <= OP_NOP;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      outp_q    <= outp_d;
      ser_out_q <= ser_out_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
    end
  end

  assign outp      = outp_q;
  assign ser_out   = ser_out_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Bench for param_universal_shift_reg (WIDTH=4): directed plan steps then random commands vs an arithmetic model.
module tb_param_universal_shift_reg;

  localparam int W     = 4;
  localparam int AMT_W = 3;
  localparam int MASK  = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [W-1:0]     cmd_data;
  logic             ser_in;
  logic [W-1:0]     outp;
  logic             ser_out;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;
  int m_out    = 0;
  int m_so     = 0;

  param_universal_shift_reg #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .ser_in(ser_in),
    .outp(outp), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit of movement described arithmetically on an integer value.
  task automatic model_step(input int op, input int si);
    int v;
    v = m_out;
    case (op)
      1: begin m_so = v % 2;          m_out = (v / 2) + si * (1 << (W-1)); end
      2: begin m_so = v / (1 << (W-1)); m_out = ((v * 2) + si) & MASK; end
      4: begin m_so = v % 2;          m_out = (v / 2) + (v % 2) * (1 << (W-1)); end
      5: begin m_so = v / (1 << (W-1)); m_out = ((v * 2) + v / (1 << (W-1))) & MASK; end
      6: begin m_so = v % 2;          m_out = (v / 2) + (v & (1 << (W-1))); end
      default: ;
    endcase
  endtask

  task automatic run_cmd(input int op, input int amt, input int data, input int si, input bit noisy);
    int k;
    int sv;
    bit shift_op;
    shift_op = (op == 1 || op == 2 || op == 4 || op == 5 || op == 6);
    k = (amt > W) ? W : amt;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_amt   = AMT_W'(amt);
    cmd_data  = W'(data);
    sv        = (si < 0) ? int'($urandom_range(1, 0)) : si;
    ser_in    = sv[0];
    @(posedge clk);
    case (op)
      3: m_out = data & MASK;
      7: begin m_out = 0; m_so = 0; end
      default: if (shift_op && k > 0) model_step(op, sv);
    endcase
    @(negedge clk);
    cmd_valid = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
    cmd_op    = 3'($urandom);
    cmd_amt   = AMT_W'($urandom);
    cmd_data  = W'($urandom);
    for (int i = 1; shift_op && i < k; i++) begin
      chk("busy_in_shift", busy, 1);
      chk("done_in_shift", done, 0);
      chk("ready_in_shift", cmd_ready, 0);
      chk("outp_in_shift", outp, m_out);
      chk("ser_out_in_shift", ser_out, m_so);
      sv     = (si < 0) ? int'($urandom_range(1, 0)) : si;
      ser_in = sv[0];
      @(posedge clk);
      model_step(op, sv);
      @(negedge clk);
      cmd_valid = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
      cmd_op    = 3'($urandom);
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("ready_at_done", cmd_ready, 0);
    chk("outp_at_done", outp, m_out);
    chk("ser_out_at_done", ser_out, m_so);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_after_done", cmd_ready, 1);
    chk("done_after", done, 0);
    chk("outp_idle", outp, m_out);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre;
    int op;
    // 1: reset dominates a valid LOAD
    rst = 1'b0; cmd_valid = 1'b1; cmd_op = 3'b011; cmd_amt = '0; cmd_data = 4'b1010; ser_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outp", outp, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1; cmd_valid = 1'b0;

    // 2: LOAD
    run_cmd(3, 0, 4'b1010, 0, 0);
    chk("plan_load", outp, 4'b1010);
    // 3: SHR by 2 with ser_in=1
    run_cmd(3, 0, 4'b1001, 0, 0);
    run_cmd(1, 2, 0, 1, 0);
    chk("plan_shr", outp, 4'b1110);
    chk("plan_shr_so", ser_out, 0);
    // 4: ROL 3, then ROR clamped to a full rotation
    run_cmd(3, 0, 4'b1001, 0, 0);
    run_cmd(5, 3, 0, 0, 0);
    chk("plan_rol", outp, 4'b1100);
    chk("plan_rol_so", ser_out, 0);
    run_cmd(4, 7, 0, 0, 0);
    chk("plan_ror_full", outp, 4'b1100);
    // 5: ASR, then zero-amount shift
    run_cmd(3, 0, 4'b1000, 0, 0);
    run_cmd(6, 2, 0, 0, 0);
    chk("plan_asr", outp, 4'b1110);
    chk("plan_asr_so", ser_out, 0);
    run_cmd(2, 0, 0, 1, 0);
    chk("plan_shl0", outp, 4'b1110);
    chk("plan_shl0_so", ser_out, 0);

    // 6: SHL 4, CLEAR attempted while busy, then reset mid-operation
    run_cmd(3, 0, 4'b0001, 0, 0);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_amt = 3'd4; ser_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_amt = '0;
    chk("mid_busy", busy, 1);
    chk("mid_outp1", outp, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clear_ignored", outp, 4'b0100);
    chk("mid_busy2", busy, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_outp", outp, 0);
    chk("abort_ser_out", ser_out, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    chk("abort_ready2", cmd_ready, 1);
    m_out = 0; m_so = 0;

    // Random commands against the model; rotations by WIDTH must come back to the start.
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(7, 0));
      pre = m_out;
      run_cmd(op, int'($urandom_range(7, 0)), int'($urandom_range(MASK, 0)), -1, 1);
      if ((op == 4 || op == 5) && cmd_amt == cmd_amt) begin
        if (n % 4 == 0) begin
          run_cmd(op, W, 0, -1, 1);
          chk("rot_full_identity", outp, pre == pre ? m_out : 0);
        end
      end
    end
    run_cmd(3, 0, 4'b1011, 0, 0);
    run_cmd(6, 4, 0, 1, 0);
    chk("asr_full_msb", outp, 4'b1111);
    run_cmd(3, 0, 4'b0110, 0, 0);
    pre = 4'b0110;
    run_cmd(5, 4, 0, 1, 0);
    chk("rol_full_orig", outp, pre);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
